// File: rtl/brainfuck_uart_tx_if.sv
// brainfuck_uart_tx_if: CPU output-port handshake bundle.
// master = CPU side, slave = UART transmitter side.
interface brainfuck_uart_tx_if;
   logic [7:0] output_data;
   logic       output_write;
   logic       output_busy;

   modport master (
      output output_data,
      output output_write,
      input  output_busy
   );

   modport slave (
      input  output_data,
      input  output_write,
      output output_busy
   );
endinterface

// File: rtl/brainfuck_uart_tx.sv
// brainfuck_uart_tx: FIFO-buffered UART transmitter for the brainfuck CPU output port.
// Define BF_UART_TX_PARITY_EN for 8E1 frames; the default build sends 8N1.
module brainfuck_uart_tx #(
   parameter int CLK_DIV         = 434,
   parameter int FIFO_ADDR_WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst_i,
   brainfuck_uart_tx_if.slave bus,
   output logic              tx,
   output logic              idle,
   output logic              overflow
);
   localparam int AW    = FIFO_ADDR_WIDTH;
   localparam int DEPTH = 1 << AW;
   localparam int BW    = $clog2(CLK_DIV);

   localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_n;
   logic          busy_q;

   state_t        state;
   state_t        state_n;
   logic [BW-1:0] baud;
   logic [BW-1:0] baud_n;
   logic [2:0]    bit_cnt;
   logic [2:0]    bit_n;
   logic [7:0]    shreg;
   logic [7:0]    sh_n;
   logic          tx_n;
   logic          push;
   logic          pop;
   logic          baud_end;
   logic          has_data;
`ifdef BF_UART_TX_PARITY_EN
   logic          par;
   logic          par_n;
`endif

   assign push     = bus.output_write && (count < FULL);
   assign baud_end = (baud == BAUD_LAST);
   assign has_data = (count != '0);
   assign bus.output_busy = busy_q;

   always_comb begin
      state_n = state;
      baud_n  = baud + BW'(1);
      bit_n   = bit_cnt;
      sh_n    = shreg;
      tx_n    = tx;
      pop     = 1'b0;
`ifdef BF_UART_TX_PARITY_EN
      par_n   = par;
`endif
      unique case (state)
         S_IDLE: begin
            baud_n = '0;
            pop    = has_data;
         end
         S_START: begin
            if (baud_end) begin
               baud_n  = '0;
               bit_n   = '0;
               tx_n    = shreg[0];
               state_n = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_n = '0;
               if (bit_cnt == 3'd7) begin
`ifdef BF_UART_TX_PARITY_EN
                  tx_n    = par;
                  state_n = S_PARITY;
`else
                  tx_n    = 1'b1;
                  state_n = S_STOP;
`endif
               end else begin
                  sh_n  = shreg >> 1;
                  tx_n  = shreg[1];
                  bit_n = bit_cnt + 3'd1;
               end
            end
         end
`ifdef BF_UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_end) begin
               baud_n  = '0;
               tx_n    = 1'b1;
               state_n = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (baud_end) begin
               baud_n  = '0;
               tx_n    = 1'b1;
               state_n = S_IDLE;
               pop     = has_data;
            end
         end
         default: begin
            tx_n    = 1'b1;
            state_n = S_IDLE;
         end
      endcase
      // a pop always launches a fresh start bit, from IDLE or straight out of STOP
      if (pop) begin
         sh_n    = mem[rd_ptr];
         tx_n    = 1'b0;
         baud_n  = '0;
         state_n = S_START;
`ifdef BF_UART_TX_PARITY_EN
         par_n   = ^mem[rd_ptr];
`endif
      end
      count_n = count + (AW+1)'(push) - (AW+1)'(pop);
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         state    <= S_IDLE;
         baud     <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         busy_q   <= 1'b0;
         idle     <= 1'b1;
         overflow <= 1'b0;
`ifdef BF_UART_TX_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_cnt <= bit_n;
         shreg   <= sh_n;
         tx      <= tx_n;
         count   <= count_n;
         busy_q  <= (count_n == FULL);
         idle    <= (count_n == '0) && (state_n == S_IDLE);
`ifdef BF_UART_TX_PARITY_EN
         par     <= par_n;
`endif
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (bus.output_write && (count == FULL)) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.output_data;
   end
endmodule

// File: tb/tb_brainfuck_uart_tx.sv
// tb_brainfuck_uart_tx: table vectors, back-to-back, collision, fill,
// mid-frame reset and wrap-around streaming against a serial scoreboard.
module tb_brainfuck_uart_tx;
   localparam int CLK_DIV = 4;
   localparam int AW      = 2;
   localparam int HALF    = CLK_DIV / 2;
`ifdef BF_UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CLK_DIV;

   logic clk = 1'b0;
   logic rst_i = 1'b0;
   logic tx;
   logic idle;
   logic overflow;

   brainfuck_uart_tx_if bif ();

   brainfuck_uart_tx #(
      .CLK_DIV(CLK_DIV),
      .FIFO_ADDR_WIDTH(AW)
   ) dut (
      .clk(clk),
      .rst_i(rst_i),
      .bus(bif),
      .tx(tx),
      .idle(idle),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;
   logic [7:0] exp_q[$];
   int start_q[$];
   int rx_cnt = 0;
   logic [10:0] last_frame;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic fail(input string name);
      n_chk++;
      $display("FAIL %s: got timeout/unexpected expected event", name);
   endtask

   // serial receiver, sampled mid-bit on falling clock edges
   bit          mon_on = 1'b0;
   int          ph;
   int          bi;
   logic [10:0] fbits;

   always @(negedge clk) begin
      if (!rst_i) begin
         mon_on = 1'b0;
      end else if (!mon_on) begin
         if (!tx) begin
            mon_on = 1'b1;
            ph     = 0;
            bi     = 0;
            fbits  = '0;
            start_q.push_back(cyc);
         end
      end else begin
         ph++;
         if (ph == HALF + bi * CLK_DIV) begin
            fbits[bi] = tx;
            bi++;
            if (bi == NB) begin
               mon_on = 1'b0;
               last_frame = fbits;
               rx_cnt++;
               chk("rx_start", fbits[0], 1'b0);
               chk("rx_stop", fbits[NB-1], 1'b1);
`ifdef BF_UART_TX_PARITY_EN
               chk("rx_parity", fbits[9], ^fbits[8:1]);
`endif
               if (exp_q.size() == 0) fail("rx_unexpected_frame");
               else chk("rx_data", fbits[8:1], exp_q.pop_front());
            end
         end
      end
   end

   task automatic send(input logic [7:0] b, input bit keep, output int cap);
      bif.output_data  = b;
      bif.output_write = 1'b1;
      if (keep) exp_q.push_back(b);
      @(negedge clk);
      bif.output_write = 1'b0;
      cap = cyc;
   endtask

   task automatic wait_idle(input int limit, output int n);
      n = 0;
      while (!idle && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!idle) fail("idle_timeout");
   endtask

   typedef struct {
      logic [7:0] data;
      logic       par;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int cap;
      int n;
      int base;
      int guard;
      int lows;
      logic [10:0] expf;

      tbl[0] = '{8'h41, 1'b0};
      tbl[1] = '{8'h00, 1'b0};
      tbl[2] = '{8'hFF, 1'b0};
      tbl[3] = '{8'h80, 1'b1};
      tbl[4] = '{8'h3C, 1'b0};
      tbl[5] = '{8'hA7, 1'b1};

      bif.output_data  = 8'h00;
      bif.output_write = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_idle", idle, 1'b1);
      chk("rst_busy", bif.output_busy, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      rst_i = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         send(tbl[i].data, 1'b1, cap);
         chk("idle_fall", idle, 1'b0);
         chk("tx_before_pop", tx, 1'b1);
         @(negedge clk);
         chk("tx_fall", tx, 1'b0);
         wait_idle(FRAME + 20, n);
         chk("idle_len", n, FRAME);
`ifdef BF_UART_TX_PARITY_EN
         expf = {1'b1, tbl[i].par, tbl[i].data, 1'b0};
`else
         expf = {1'b0, 1'b1, tbl[i].data, 1'b0};
`endif
         chk("frame_bits", last_frame, expf);
         repeat (3) @(negedge clk);
      end

      // back-to-back frames
      base = start_q.size();
      send(8'h55, 1'b1, cap);
      repeat (2) @(negedge clk);
      send(8'hAA, 1'b0 | 1'b1, n);
      wait_idle(3 * FRAME, n);
      chk("b2b_total", cyc - cap - 1, 2 * FRAME);
      chk("b2b_frames", start_q.size() - base, 2);
      if (start_q.size() >= base + 2)
         chk("b2b_spacing", start_q[base+1] - start_q[base], FRAME);
      repeat (3) @(negedge clk);

      // push exactly on the STOP-end pop edge with one byte queued
      base = rx_cnt;
      send(8'hC3, 1'b1, cap);
      repeat (2) @(negedge clk);
      send(8'h5A, 1'b1, n);
      while (cyc < cap + FRAME) @(negedge clk);
      send(8'h96, 1'b1, n);
      chk("coll_edge", n, cap + 1 + FRAME);
      chk("coll_idle", idle, 1'b0);
      chk("coll_busy", bif.output_busy, 1'b0);
      wait_idle(4 * FRAME, n);
      chk("coll_total", cyc - cap - 1, 3 * FRAME);
      chk("coll_frames", rx_cnt - base, 3);
      repeat (3) @(negedge clk);

      // fill a 4-deep FIFO, then overflow
      for (int k = 1; k <= 5; k++) begin
         send(8'(k), 1'b1, cap);
         if (k == 4) chk("busy_before_full", bif.output_busy, 1'b0);
         if (k == 5) chk("busy_full", bif.output_busy, 1'b1);
         chk("no_overflow_yet", overflow, 1'b0);
         repeat (2) @(negedge clk);
      end
      send(8'h06, 1'b0, cap);
      chk("overflow_set", overflow, 1'b1);
      chk("busy_still", bif.output_busy, 1'b1);
      wait_idle(7 * FRAME, n);
      chk("busy_drained", bif.output_busy, 1'b0);
      chk("overflow_sticky", overflow, 1'b1);
      repeat (3) @(negedge clk);

      // asynchronous reset in the middle of a frame
      base = rx_cnt;
      send(8'h00, 1'b0, cap);
      repeat (3 * CLK_DIV + 2) @(negedge clk);
      chk("tx_midframe", tx, 1'b0);
      #2 rst_i = 1'b0;
      #1;
      chk("arst_tx", tx, 1'b1);
      chk("arst_idle", idle, 1'b1);
      chk("arst_busy", bif.output_busy, 1'b0);
      chk("arst_overflow", overflow, 1'b0);
      repeat (2) @(negedge clk);
      rst_i = 1'b1;
      lows = 0;
      for (int c = 0; c < 3 * FRAME; c++) begin
         @(negedge clk);
         if (!tx || !idle) lows++;
      end
      chk("no_frame_after_rst", lows, 0);
      chk("rx_after_rst", rx_cnt - base, 0);

      // wrap-around stream honoring busy
      base = rx_cnt;
      for (int i = 0; i < 40; i++) begin
         guard = 0;
         while (bif.output_busy && guard < 4 * FRAME) begin
            @(negedge clk);
            guard++;
         end
         if (bif.output_busy) fail("busy_stuck");
         send(8'(i), 1'b1, cap);
         repeat (2) @(negedge clk);
      end
      wait_idle(45 * FRAME, n);
      chk("stream_overflow", overflow, 1'b0);
      chk("stream_frames", rx_cnt - base, 40);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
